pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/forward controller for the 5-stage RISC-V pipeline.
- Drives the stall and flush inputs of the F/D/E/M pipeline registers.
- Sequences a post-reset pipeline purge, load-use stalls, branch redirects and a fixed-latency multi-cycle (mul/div) execute op.
- Maintains saturating performance counters.

Parameters:
- MD_LATENCY, 4: cycles a mul/div op occupies E; legal range 2..16.
- INIT_CYCLES, 2: post-reset purge length in cycles; legal range 1..15.
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rs1D, rs2D  in  5  source registers of the instruction in D.
- rs1E, rs2E  in  5  source registers of the instruction in E.
- rdE, rdM, rdW  in  5  destination registers of the instructions in E, M and W.
- loadE  in  1  instruction in E is a load.
- regWriteM, regWriteW  in  1  register-write enables of M and W.
- pcSrcE  in  1  branch/jump redirect resolved in E.
- mdStartE  in  1  mul/div op present in E; first cycle only.
- stallF, stallD, stallE  out  1  hold the F, D and E registers.
- flushD, flushE, flushM  out  1  zero the D, E and M registers.
- forwardAE, forwardBE  out  2  operand bypass selects: 00 = register file, 01 = W, 10 = M.
- mdDoneE  out  1  final cycle of the mul/div op; result valid.
- stallCycles  out  CNT_WIDTH  count of cycles with stallF=1 in RUN/MDBUSY.
- redirectCount  out  CNT_WIDTH  count of accepted redirects.

Behaviour:
- Reset:
  - A clock edge with reset=1 forces state=INIT, initCnt=INIT_CYCLES-1, mdCnt=0, both counters=0.
  - Reset mid-operation aborts any mul/div op; no mdDoneE is produced.
- FSM states: INIT, RUN, MDBUSY. Outputs are combinational from state, counters and inputs.
- INIT:
  - Outputs: stallF=1, flushD=flushE=flushM=1, all other stall/flush=0, mdDoneE=0.
  - initCnt decrements each cycle; at 0 -> RUN.
  - Total purge is exactly INIT_CYCLES cycles.
- RUN:
  - lwStall = loadE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
  - If mdStartE=1:
    - stallF=stallD=stallE=1, flushM=1.
    - mdCnt <= MD_LATENCY-2; next state MDBUSY.
    - pcSrcE and lwStall are ignored that cycle.
  - Else if pcSrcE=1:
    - flushD=flushE=1; stallF=stallD=0. The redirect overrides lwStall.
    - redirectCount += 1.
  - Else if lwStall=1: stallF=stallD=1, flushE=1.
  - Otherwise all stall/flush outputs are 0.
- MDBUSY:
  - If mdCnt!=0: stallF=stallD=stallE=1, flushM=1, mdCnt -= 1.
  - If mdCnt==0: mdDoneE=1, no stalls or flushes, -> RUN.
  - pcSrcE, loadE and mdStartE are ignored in MDBUSY.
  - Net effect: the op occupies E for exactly MD_LATENCY cycles, counting the start cycle.
- Forwarding (combinational, all states):
  - forwardAE=10 if regWriteM & rdM!=0 & rdM==rs1E.
  - Else forwardAE=01 if regWriteW & rdW!=0 & rdW==rs1E.
  - Else forwardAE=00.
  - forwardBE uses the same rule on rs2E.
  - M takes priority over W.
- Counters:
  - Increment on the clock edge after the qualifying cycle.
  - Saturate at all-ones (no wrap).
  - Do not count during INIT.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - typedef enum ctrl_state_t {INIT, RUN, MDBUSY}.
  - Constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - typedef reg_addr_t (logic[4:0]).
- Sub-module hazard_forward_unit: purely combinational forwardAE/forwardBE logic, instantiated once.

Test Plan:
- Reset, then release -> stallF=flushD=flushE=flushM=1 for exactly 2 cycles; RUN on the 3rd cycle; counters=0.
- RUN, loadE=1, rdE=5, rs2D=5 -> stallF=stallD=flushE=1 for one cycle. Repeat with rdE=0 -> no stall.
- loadE=1, rdE=5, rs1D=5 and pcSrcE=1 in the same cycle -> flushD=flushE=1, stallF=stallD=0, redirectCount goes 0 -> 1.
- mdStartE=1 pulse with MD_LATENCY=4 -> stallF/D/E=1 and flushM=1 for cycles 0-2, mdDoneE=1 on cycle 3, RUN on cycle 4, stallCycles=3. A pcSrcE=1 injected on cycle 1 is ignored.
- rs1E=7, rdM=7, regWriteM=1, rdW=7, regWriteW=1 -> forwardAE=10. Drop regWriteM -> 01. rdM=rdW=0 -> 00.
- Assert reset on cycle 2 of MDBUSY -> INIT next cycle, mdDoneE never asserted, counters=0. With stallCycles preloaded near all-ones via long load-use stalling -> saturates at all-ones.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        MDBUSY = 2'd2
    } ctrl_state_t;

    typedef logic [4:0] reg_addr_t;
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_W  = 2'b01;
    localparam fwd_sel_t FWD_M  = 2'b10;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic addr_match(input reg_addr_t rd, input reg_addr_t rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side hazard inputs and controller outputs.
// Latency: n/a (wires only).
// Backpressure: n/a; stalls are expressed through the stall/flush outputs.
// Ports: master = pipeline datapath (drives register addresses and op flags),
//        slave  = hazard controller (drives stall/flush/forward/done/counters).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    import pipeline_ctrl_pkg::*;

    reg_addr_t rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic      loadE, regWriteM, regWriteW, pcSrcE, mdStartE;

    logic      stallF, stallD, stallE;
    logic      flushD, flushE, flushM;
    fwd_sel_t  forwardAE, forwardBE;
    logic      mdDoneE;
    logic [CNT_WIDTH-1:0] stallCycles, redirectCount;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output loadE, regWriteM, regWriteW, pcSrcE, mdStartE,
        input  stallF, stallD, stallE, flushD, flushE, flushM,
        input  forwardAE, forwardBE, mdDoneE, stallCycles, redirectCount
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  loadE, regWriteM, regWriteW, pcSrcE, mdStartE,
        output stallF, stallD, stallE, flushD, flushE, flushM,
        output forwardAE, forwardBE, mdDoneE, stallCycles, redirectCount
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_forward.sv
// Operand bypass select for the two E-stage source operands.
// Latency: combinational.
// Backpressure: none.
// Ports: rs1E/rs2E sources in E, rdM/rdW + write enables of M/W -> forwardAE/forwardBE.
module hazard_forward_unit
    import pipeline_ctrl_pkg::*;
(
    input  reg_addr_t rs1E,
    input  reg_addr_t rs2E,
    input  reg_addr_t rdM,
    input  reg_addr_t rdW,
    input  logic      regWriteM,
    input  logic      regWriteW,
    output fwd_sel_t  forwardAE,
    output fwd_sel_t  forwardBE
);

    // M holds the younger result, so it wins over W.
    function automatic fwd_sel_t fwd_sel(input reg_addr_t rs, input reg_addr_t rd_m,
                                         input logic wr_m, input reg_addr_t rd_w,
                                         input logic wr_w);
        if (wr_m && addr_match(rd_m, rs)) return FWD_M;
        if (wr_w && addr_match(rd_w, rs)) return FWD_W;
        return FWD_RF;
    endfunction

    assign forwardAE = fwd_sel(rs1E, rdM, regWriteM, rdW, regWriteW);
    assign forwardBE = fwd_sel(rs2E, rdM, regWriteM, rdW, regWriteW);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline with post-reset purge and mul/div sequencing.
// Latency: stall/flush/forward outputs are combinational; counters update on the following edge.
// Backpressure: holds F/D/E via stall outputs during load-use, mul/div and purge; no input handshake.
// Ports: clk, reset (sync, active-high); hz = slave side of pipeline_hazard_ctrl_if.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_LATENCY  = 4,
    parameter int INIT_CYCLES = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_hazard_ctrl_if.slave   hz
);

    ctrl_state_t          state;
    logic [3:0]           initCnt;
    logic [3:0]           mdCnt;
    logic [CNT_WIDTH-1:0] stallCnt;
    logic [CNT_WIDTH-1:0] redirCnt;

    logic lwStall;
    logic stallF, stallD, stallE, flushD, flushE, flushM, mdDoneE;
    logic stallInc, redirInc;

    assign lwStall = hz.loadE && (addr_match(hz.rdE, hz.rs1D) || addr_match(hz.rdE, hz.rs2D));

    always_comb begin
        stallF  = 1'b0;
        stallD  = 1'b0;
        stallE  = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        flushM  = 1'b0;
        mdDoneE = 1'b0;
        case (state)
            INIT: begin
                stallF = 1'b1;
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
            end
            RUN: begin
                // mul/div start beats a redirect; a redirect beats load-use
                // since the dependent instruction is being squashed anyway.
                if (hz.mdStartE) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    flushM = 1'b1;
                end else if (hz.pcSrcE) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (lwStall) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
            end
            MDBUSY: begin
                if (mdCnt != 4'd0) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    flushM = 1'b1;
                end else begin
                    mdDoneE = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign stallInc = (state != INIT) && stallF;
    assign redirInc = (state == RUN) && !hz.mdStartE && hz.pcSrcE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            initCnt  <= 4'(INIT_CYCLES - 1);
            mdCnt    <= 4'd0;
            stallCnt <= '0;
            redirCnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (initCnt == 4'd0) state <= RUN;
                    else                 initCnt <= initCnt - 4'd1;
                end
                RUN: begin
                    // Start cycle counts as the first of MD_LATENCY cycles in E,
                    // and the done cycle is the last, hence the -2.
                    if (hz.mdStartE) begin
                        mdCnt <= 4'(MD_LATENCY - 2);
                        state <= MDBUSY;
                    end
                end
                MDBUSY: begin
                    if (mdCnt != 4'd0) mdCnt <= mdCnt - 4'd1;
                    else               state <= RUN;
                end
                default: state <= INIT;
            endcase

            if (stallInc && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
            if (redirInc && (redirCnt != '1)) redirCnt <= redirCnt + 1'b1;
        end
    end

    hazard_forward_unit u_fwd (
        .rs1E      (hz.rs1E),
        .rs2E      (hz.rs2E),
        .rdM       (hz.rdM),
        .rdW       (hz.rdW),
        .regWriteM (hz.regWriteM),
        .regWriteW (hz.regWriteW),
        .forwardAE (hz.forwardAE),
        .forwardBE (hz.forwardBE)
    );

    assign hz.stallF        = stallF;
    assign hz.stallD        = stallD;
    assign hz.stallE        = stallE;
    assign hz.flushD        = flushD;
    assign hz.flushE        = flushE;
    assign hz.flushM        = flushM;
    assign hz.mdDoneE       = mdDoneE;
    assign hz.stallCycles   = stallCnt;
    assign hz.redirectCount = redirCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MD_LATENCY=4, INIT_CYCLES=2, CNT_WIDTH=5).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// ctl = {stallF, stallD, stallE, flushD, flushE, flushM, mdDoneE}.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 5;

    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_INIT = 7'b1001110;
    localparam logic [6:0] C_LW   = 7'b1100100;
    localparam logic [6:0] C_RDIR = 7'b0001100;
    localparam logic [6:0] C_MD   = 7'b1110010;
    localparam logic [6:0] C_DONE = 7'b0000001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_ctrl_if #(.CNT_WIDTH(CW)) hz();

    pipeline_hazard_ctrl #(
        .MD_LATENCY (4),
        .INIT_CYCLES(2),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    always #5 clk = ~clk;

    wire [6:0] ctl = {hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE, hz.flushM, hz.mdDoneE};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.rs1D = 5'd0; hz.rs2D = 5'd0; hz.rs1E = 5'd0; hz.rs2E = 5'd0;
        hz.rdE  = 5'd0; hz.rdM  = 5'd0; hz.rdW  = 5'd0;
        hz.loadE = 1'b0; hz.regWriteM = 1'b0; hz.regWriteW = 1'b0;
        hz.pcSrcE = 1'b0; hz.mdStartE = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if (ctl !== C_INIT) begin
                errors++;
                $display("FAIL reset_purge_c%0d ctl=%b expected=%b", c, ctl, C_INIT);
            end
            checks++;
            if (hz.stallCycles !== 5'd0 || hz.redirectCount !== 5'd0) begin
                errors++;
                $display("FAIL reset_counters_c%0d stall=%0d redir=%0d expected=0/0", c, hz.stallCycles, hz.redirectCount);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL reset_run_c3 ctl=%b expected=%b", ctl, C_IDLE);
        end
        step();
        checks++;
        if (hz.stallCycles !== 5'd0) begin
            errors++;
            $display("FAIL reset_nocount_init stall=%0d expected=0", hz.stallCycles);
        end
    endtask

    task automatic test_load_use();
        hz.loadE = 1'b1; hz.rdE = 5'd5; hz.rs2D = 5'd5; hz.rs1D = 5'd3;
        @(negedge clk);
        checks++;
        if (ctl !== C_LW) begin
            errors++;
            $display("FAIL load_use_rs2 ctl=%b expected=%b", ctl, C_LW);
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (ctl !== C_IDLE || hz.stallCycles !== 5'd1) begin
            errors++;
            $display("FAIL load_use_after ctl=%b stall=%0d expected=%b/1", ctl, hz.stallCycles, C_IDLE);
        end
        step();
        // Destination x0 must never stall.
        hz.loadE = 1'b1; hz.rdE = 5'd0; hz.rs1D = 5'd0; hz.rs2D = 5'd0;
        @(negedge clk);
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL load_use_x0 ctl=%b expected=%b", ctl, C_IDLE);
        end
        step();
        // Matching register but not a load: no stall.
        hz.loadE = 1'b0; hz.rdE = 5'd5; hz.rs1D = 5'd5;
        @(negedge clk);
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL load_use_noload ctl=%b expected=%b", ctl, C_IDLE);
        end
        step();
        clear_inputs();
        checks++;
        if (hz.stallCycles !== 5'd1) begin
            errors++;
            $display("FAIL load_use_count stall=%0d expected=1", hz.stallCycles);
        end
    endtask

    task automatic test_redirect();
        hz.loadE = 1'b1; hz.rdE = 5'd5; hz.rs1D = 5'd5; hz.pcSrcE = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== C_RDIR || hz.redirectCount !== 5'd0) begin
            errors++;
            $display("FAIL redirect_over_lw ctl=%b redir=%0d expected=%b/0", ctl, hz.redirectCount, C_RDIR);
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (hz.redirectCount !== 5'd1 || hz.stallCycles !== 5'd1) begin
            errors++;
            $display("FAIL redirect_count redir=%0d stall=%0d expected=1/1", hz.redirectCount, hz.stallCycles);
        end
        step();
    endtask

    task automatic test_muldiv();
        logic [6:0] exp_ctl [5] = '{C_MD, C_MD, C_MD, C_DONE, C_IDLE};
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c == 0) hz.mdStartE = 1'b1;
            if (c == 1) hz.pcSrcE = 1'b1;
            if (c == 2) begin hz.loadE = 1'b1; hz.rdE = 5'd4; hz.rs1D = 5'd4; end
            @(negedge clk);
            checks++;
            if (ctl !== exp_ctl[c]) begin
                errors++;
                $display("FAIL muldiv_c%0d ctl=%b expected=%b", c, ctl, exp_ctl[c]);
            end
            step();
        end
        clear_inputs();
        // 1 earlier load-use stall + 3 mul/div stall cycles; the ignored redirect is not counted.
        checks++;
        if (hz.stallCycles !== 5'd4 || hz.redirectCount !== 5'd1) begin
            errors++;
            $display("FAIL muldiv_counts stall=%0d redir=%0d expected=4/1", hz.stallCycles, hz.redirectCount);
        end
    endtask

    task automatic test_forward();
        hz.rs1E = 5'd7; hz.rs2E = 5'd7; hz.rdM = 5'd7; hz.rdW = 5'd7;
        hz.regWriteM = 1'b1; hz.regWriteW = 1'b1;
        #2;
        checks++;
        if (hz.forwardAE !== 2'b10 || hz.forwardBE !== 2'b10) begin
            errors++;
            $display("FAIL fwd_m_priority A=%b B=%b expected=10/10", hz.forwardAE, hz.forwardBE);
        end
        hz.regWriteM = 1'b0;
        #2;
        checks++;
        if (hz.forwardAE !== 2'b01 || hz.forwardBE !== 2'b01) begin
            errors++;
            $display("FAIL fwd_w A=%b B=%b expected=01/01", hz.forwardAE, hz.forwardBE);
        end
        hz.regWriteM = 1'b1; hz.rdM = 5'd0; hz.rdW = 5'd0;
        #2;
        checks++;
        if (hz.forwardAE !== 2'b00 || hz.forwardBE !== 2'b00) begin
            errors++;
            $display("FAIL fwd_rd_zero A=%b B=%b expected=00/00", hz.forwardAE, hz.forwardBE);
        end
        hz.rs1E = 5'd0;
        #2;
        checks++;
        if (hz.forwardAE !== 2'b00) begin
            errors++;
            $display("FAIL fwd_x0_src A=%b expected=00", hz.forwardAE);
        end
        hz.rs1E = 5'd7; hz.rs2E = 5'd3; hz.rdM = 5'd7; hz.rdW = 5'd3;
        #2;
        checks++;
        if (hz.forwardAE !== 2'b10 || hz.forwardBE !== 2'b01) begin
            errors++;
            $display("FAIL fwd_split A=%b B=%b expected=10/01", hz.forwardAE, hz.forwardBE);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_md();
        hz.mdStartE = 1'b1;
        step();
        hz.mdStartE = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (ctl !== C_MD) begin
            errors++;
            $display("FAIL rst_md_busy ctl=%b expected=%b", ctl, C_MD);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== C_INIT || hz.stallCycles !== 5'd0 || hz.redirectCount !== 5'd0) begin
            errors++;
            $display("FAIL rst_md_init ctl=%b stall=%0d redir=%0d expected=%b/0/0", ctl, hz.stallCycles, hz.redirectCount, C_INIT);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (hz.mdDoneE !== 1'b0) begin
                errors++;
                $display("FAIL rst_md_no_done_c%0d mdDoneE=%b expected=0", c, hz.mdDoneE);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL rst_md_run ctl=%b expected=%b", ctl, C_IDLE);
        end
        step();
    endtask

    task automatic test_saturate();
        hz.loadE = 1'b1; hz.rdE = 5'd9; hz.rs1D = 5'd9;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 30) begin
                checks++;
                if (hz.stallCycles !== 5'd30) begin
                    errors++;
                    $display("FAIL sat_progress stall=%0d expected=30", hz.stallCycles);
                end
            end
            if (c == 31) begin
                checks++;
                if (hz.stallCycles !== 5'd31) begin
                    errors++;
                    $display("FAIL sat_reach stall=%0d expected=31", hz.stallCycles);
                end
            end
        end
        checks++;
        if (hz.stallCycles !== 5'd31) begin
            errors++;
            $display("FAIL sat_hold stall=%0d expected=31", hz.stallCycles);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_redirect();
        test_muldiv();
        test_forward();
        test_reset_mid_md();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
